// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared state encoding for the PWM duty-cycle generator
package pwm_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/pwm_gen_if.sv
// rtl/pwm_gen_if.sv - count, duty handshake and waveform bundle for pwm_gen
interface pwm_gen_if #(
    parameter int Width = 4
);

    logic [Width-1:0] cnt_i;
    logic [Width-1:0] duty_i;
    logic             duty_valid_i;
    logic             duty_ready_o;
    logic             pwm_o;
    logic             period_o;

    modport master (
        output cnt_i,
        output duty_i,
        output duty_valid_i,
        input  duty_ready_o,
        input  pwm_o,
        input  period_o
    );

    modport slave (
        input  cnt_i,
        input  duty_i,
        input  duty_valid_i,
        output duty_ready_o,
        output pwm_o,
        output period_o
    );

endinterface

// File: rtl/dff.sv
// rtl/dff.sv - width-parameterised enable flop with synchronous active-high reset to zero
module dff #(
    parameter int Width = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [Width-1:0] d,
    output logic [Width-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/lt_cmp.sv
// rtl/lt_cmp.sv - combinational unsigned less-than comparator
module lt_cmp #(
    parameter int Width = 4
) (
    input  logic [Width-1:0] a,
    input  logic [Width-1:0] b,
    output logic             lt
);

    assign lt = (a < b);

endmodule

// File: rtl/pwm_gen.sv
// rtl/pwm_gen.sv - registered PWM generator with period-boundary duty updates
module pwm_gen
    import pwm_pkg::*;
#(
    parameter int Width = DEFAULT_WIDTH
) (
    input  logic     clk_i,
    input  logic     rst_i,
    pwm_gen_if.slave bus
);

    state_t           state_q;
    logic             pwm_q;
    logic             period_q;
    logic             pend_valid_q;
    logic [Width-1:0] cnt_q;
    logic [Width-1:0] pend_q;
    logic [Width-1:0] active_q;
    logic [Width-1:0] d_eff;
    logic             cnt_zero;
    logic             entering;
    logic             period_start;
    logic             apply;
    logic             transfer;
    logic             cnt_lt_duty;

    assign cnt_zero = (bus.cnt_i == '0);
    assign entering = (state_q == IDLE) && cnt_zero;
    // A count parked at zero must not retrigger, hence the check against last cycle's count.
    assign period_start = entering || ((state_q == RUN) && cnt_zero && (cnt_q != '0));
    assign apply        = period_start && pend_valid_q;
    assign transfer     = bus.duty_valid_i && !pend_valid_q;
    assign d_eff        = apply ? pend_q : active_q;

    dff #(.Width(Width)) u_cnt_q (
        .clk (clk_i),
        .rst (rst_i),
        .en  (1'b1),
        .d   (bus.cnt_i),
        .q   (cnt_q)
    );

    dff #(.Width(Width)) u_pend_q (
        .clk (clk_i),
        .rst (rst_i),
        .en  (transfer),
        .d   (bus.duty_i),
        .q   (pend_q)
    );

    dff #(.Width(Width)) u_active_q (
        .clk (clk_i),
        .rst (rst_i),
        .en  (apply),
        .d   (pend_q),
        .q   (active_q)
    );

    lt_cmp #(.Width(Width)) u_cmp (
        .a  (bus.cnt_i),
        .b  (d_eff),
        .lt (cnt_lt_duty)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            pwm_q        <= 1'b0;
            period_q     <= 1'b0;
            pend_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (entering) state_q <= RUN;
                RUN:  state_q <= RUN;
                default: state_q <= IDLE;
            endcase
            pwm_q    <= ((state_q == RUN) || entering) && cnt_lt_duty;
            period_q <= period_start;
            // Ready is low while pending, so apply and transfer never coincide.
            if (apply) begin
                pend_valid_q <= 1'b0;
            end else if (transfer) begin
                pend_valid_q <= 1'b1;
            end
        end
    end

    assign bus.duty_ready_o = !pend_valid_q;
    assign bus.pwm_o        = pwm_q;
    assign bus.period_o     = period_q;

endmodule

// File: tb/tb_pwm_gen.sv
// tb/tb_pwm_gen.sv - directed self-checking bench for pwm_gen
module tb_pwm_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] cp  = 4'd0;
    int         errors = 0;
    int         checks = 0;

    pwm_gen_if #(.Width(4)) bus ();

    pwm_gen #(.Width(4)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick(input bit hold);
        @(posedge clk);
        #1;
        cp = bus.cnt_i;
        if (!hold) bus.cnt_i = 4'(bus.cnt_i + 4'd1);
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b sampled_cnt=%0d", tag, obs, exp, cp);
        end
    endtask

    task automatic run_counts(input int n, input int duty, input logic rdy);
        for (int i = 0; i < n; i++) begin
            tick(1'b0);
            chk("pwm", bus.pwm_o, (int'(cp) < duty));
            chk("period", bus.period_o, (cp == 4'd0));
            chk("ready", bus.duty_ready_o, rdy);
        end
    endtask

    initial begin
        bus.cnt_i        = 4'd0;
        bus.duty_i       = 4'd0;
        bus.duty_valid_i = 1'b0;

        // reset state
        rst = 1'b1;
        tick(1'b1);
        tick(1'b1);
        chk("rst_pwm", bus.pwm_o, 1'b0);
        chk("rst_period", bus.period_o, 1'b0);
        chk("rst_ready", bus.duty_ready_o, 1'b1);
        rst = 1'b0;

        // 1: free-running, no duty request
        run_counts(32, 0, 1'b1);

        // 2: duty 5 requested at count 7
        run_counts(7, 0, 1'b1);
        bus.duty_i = 4'd5; bus.duty_valid_i = 1'b1;
        run_counts(1, 0, 1'b0);
        bus.duty_valid_i = 1'b0;
        run_counts(8, 0, 1'b0);
        run_counts(16, 5, 1'b1);

        // 3: duty 3 requested on the period-start cycle
        bus.duty_i = 4'd3; bus.duty_valid_i = 1'b1;
        run_counts(1, 5, 1'b0);
        bus.duty_valid_i = 1'b0;
        run_counts(15, 5, 1'b0);
        run_counts(16, 3, 1'b1);

        // 4: 9 then 2 held while not ready
        run_counts(2, 3, 1'b1);
        bus.duty_i = 4'd9; bus.duty_valid_i = 1'b1;
        run_counts(1, 3, 1'b0);
        bus.duty_i = 4'd2;
        run_counts(13, 3, 1'b0);
        run_counts(1, 9, 1'b1);
        run_counts(1, 9, 1'b0);
        bus.duty_valid_i = 1'b0;
        run_counts(14, 9, 1'b0);
        run_counts(16, 2, 1'b1);

        // 5: duty 15 then duty 0
        bus.duty_i = 4'd15; bus.duty_valid_i = 1'b1;
        run_counts(1, 2, 1'b0);
        bus.duty_valid_i = 1'b0;
        run_counts(15, 2, 1'b0);
        run_counts(16, 15, 1'b1);
        bus.duty_i = 4'd0; bus.duty_valid_i = 1'b1;
        run_counts(1, 15, 1'b0);
        bus.duty_valid_i = 1'b0;
        run_counts(15, 15, 1'b0);
        run_counts(32, 0, 1'b1);

        // 6: reset with 8 active and 4 pending
        bus.duty_i = 4'd8; bus.duty_valid_i = 1'b1;
        run_counts(1, 0, 1'b0);
        bus.duty_valid_i = 1'b0;
        run_counts(15, 0, 1'b0);
        run_counts(3, 8, 1'b1);
        bus.duty_i = 4'd4; bus.duty_valid_i = 1'b1;
        run_counts(1, 8, 1'b0);
        bus.duty_valid_i = 1'b0;
        run_counts(2, 8, 1'b0);
        rst = 1'b1;
        tick(1'b0);
        chk("rst6_pwm", bus.pwm_o, 1'b0);
        chk("rst6_period", bus.period_o, 1'b0);
        chk("rst6_ready", bus.duty_ready_o, 1'b1);
        rst = 1'b0;
        run_counts(9, 0, 1'b1);
        run_counts(16, 0, 1'b1);

        // count parked at zero gives one period start; jump to zero gives another
        tick(1'b1);
        chk("hold_period0", bus.period_o, 1'b1);
        tick(1'b1);
        chk("hold_period1", bus.period_o, 1'b0);
        tick(1'b1);
        chk("hold_period2", bus.period_o, 1'b0);
        bus.cnt_i = 4'd1;
        run_counts(4, 0, 1'b1);
        bus.cnt_i = 4'd0;
        run_counts(1, 0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
